irq_pending_ctrl: RTL and testbench
===================================

// Module: irq_pending_ctrl
// PURPOSE
//  Front end for the 8-input priority encoder. Detects rising edges on raw
//  request lines, holds them in a sticky pending register, applies a mask and
//  feeds the encoder. Registers the winning index and hands it to the consumer
//  over a valid/ack handshake. Clears the serviced pending bit on ack.
// PARAMETERS
//  N      8   number of request lines; the encoder width is fixed at 8
//  IDX_W  3   index width; equals clog2(N)
// PORTS
//  clk        in   1      single clock; all logic is on the rising edge
//  rst        in   1      synchronous, active-high reset
//  en         in   1      arbitration enable; a new grant starts only while en=1
//  irq_in     in   N      raw level request lines, already synchronous to clk
//  mask       in   N      1 = line excluded from arbitration; the bit still latches
//  pending    out  N      sticky pending register, unmasked view
//  req_valid  out  1      req_idx holds a granted request
//  req_idx    out  IDX_W  granted line index; bit N-1 has highest priority
//  ack        in   1      consumer accepts req_idx; sampled only while req_valid=1
// BEHAVIOUR
//  Reset:
//   - pending, irq_prev, req_valid and req_idx all reset to 0. State -> IDLE.
//   - irq_prev=0 after reset, so a line already high at release counts as an edge.
//   - Reset asserted mid-handshake drops req_valid on the next edge. The grant is lost.
//  Edge detect:
//   - rise[i] = irq_in[i] & ~irq_prev[i].
//   - irq_prev <= irq_in every cycle.
//  Pending update:
//   - pending <= (pending & ~clr) | rise.
//   - clr is one-hot on req_idx only in the ack cycle.
//   - If set and clear hit the same bit in the same cycle, set wins and the bit stays 1.
//  Eligibility and encoding:
//   - elig = pending & ~mask.
//   - The encoder is combinational on elig. Highest set bit wins.
//  FSM:
//   - IDLE: if en && elig!=0, then req_idx <= enc_out, req_valid <= 1, go GRANT.
//     Otherwise hold.
//   - GRANT: req_idx is frozen. A later higher-priority request does not preempt.
//     en falling does not retract the grant. Masking the granted line does not
//     retract it either.
//     On ack: clear pending[req_idx], req_valid <= 0, go IDLE.
//   - IDLE always lasts at least one cycle between grants. ack in IDLE is ignored.
//  Latency (edge on irq_in at cycle t, en=1, unmasked, IDLE):
//   - pending is set at t+1.
//   - req_valid is set at t+2.
//   - After ack at cycle a, req_valid=0 at a+1. The next grant is earliest at a+2.
//  Other rules:
//   - A line that re-asserts while its grant is still outstanding re-pends after
//     the ack, because set wins.
//   - A line held high produces exactly one edge. It does not re-pend until it has
//     dropped and risen again.
// STRUCTURE
//  Shared package irq_pkg:
//   - localparams N=8 and IDX_W=3.
//   - FSM state encoding: IDLE=1'b0, GRANT=1'b1.
//  Sub-module:
//   - Instantiate the existing 8-input priority_encoder for elig -> enc_out,
//     with its enable tied to 1.
//   - Edge detect, pending register and FSM stay in this module.
// TESTING
//  1 Single request:
//    - Stimulus: rst, then en=1, mask=0, pulse irq_in=8'h04 high.
//    - Response: req_valid=1, req_idx=2 two cycles after the edge.
//    - Then ack -> pending=0, req_valid=0.
//  2 Priority order:
//    - Stimulus: irq_in=8'h2E rises in one cycle.
//    - Response: grants are 5, 3, 2, 1 in that order, with one IDLE cycle between each.
//  3 No preemption:
//    - Stimulus: during GRANT idx=1, line 7 rises.
//    - Response: req_idx stays 1 until ack. The next grant is 7.
//  4 Mask:
//    - Stimulus: mask=8'h80 with lines 7 and 0 rising.
//    - Response: idx 0 is granted and pending keeps bit 7.
//    - Then clear mask -> grant 7.
//  5 Set beats clear:
//    - Stimulus: ack idx 3 in the same cycle line 3 rises again.
//    - Response: pending[3]=1 afterwards and 3 is re-granted.
//  6 Enable and reset:
//    - en=0 with pending 8'h10 -> no valid. en=1 -> grant 4.
//    - Then rst during GRANT -> req_valid=0 and pending=0 on the next cycle.

Source files
------------

// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt pending controller.
// It holds the request-line count, the index width and the two-state FSM encoding.
package irq_pkg;

  localparam int unsigned N     = 8;
  localparam int unsigned IDX_W = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

endpackage

// File: rtl/priority_encoder.sv
// 8-input combinational priority encoder. The highest set bit wins.
// Ports:
//   en    in   1      encoder enable; when low the outputs read zero
//   req   in   N      request vector
//   idx   out  IDX_W  index of the highest set request bit (combinational)
//   valid out  1      at least one request bit is set (combinational)
module priority_encoder
  import irq_pkg::*;
(
  input  logic             en,
  input  logic [N-1:0]     req,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  // An ascending scan lets a higher bit overwrite a lower one, so the highest set bit wins.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    if (en) begin
      for (int i = 0; i < int'(N); i++) begin
        if (req[i]) begin
          idx   = IDX_W'(i);
          valid = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/irq_pending_ctrl.sv
// Interrupt front end. It detects rising edges on the raw request lines and keeps
// them in a sticky pending register. Masked lines are excluded from arbitration.
// The winning index is registered and handed to the consumer over a valid/ack
// handshake.
// Ports:
//   clk       in   1      clock, rising edge
//   rst       in   1      synchronous active-high reset
//   en        in   1      arbitration enable; a new grant starts only while high
//   irq_in    in   N      raw level request lines, synchronous to clk
//   mask      in   N      1 = line excluded from arbitration; the line still latches
//   pending   out  N      sticky pending register, unmasked view
//   req_valid out  1      req_idx holds a granted request
//   req_idx   out  IDX_W  granted line index; bit N-1 has the highest priority
//   ack       in   1      consumer accepts req_idx; sampled only while req_valid is high
module irq_pending_ctrl
  import irq_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [N-1:0]     irq_in,
  input  logic [N-1:0]     mask,
  output logic [N-1:0]     pending,
  output logic             req_valid,
  output logic [IDX_W-1:0] req_idx,
  input  logic             ack
);

  state_t           state;
  state_t           state_nxt;
  logic [N-1:0]     irq_prev;
  logic [N-1:0]     rise;
  logic [N-1:0]     clr;
  logic [N-1:0]     elig;
  logic [N-1:0]     pending_nxt;
  logic [IDX_W-1:0] enc_out;
  logic             enc_valid;
  logic             req_valid_nxt;
  logic [IDX_W-1:0] req_idx_nxt;

  assign rise = irq_in & ~irq_prev;
  assign elig = pending & ~mask;

  priority_encoder u_enc (
    .en    (1'b1),
    .req   (elig),
    .idx   (enc_out),
    .valid (enc_valid)
  );

  // Next-state, handshake and pending update. A set and a clear on the same bit leave the bit set.
  always_comb begin
    state_nxt     = state;
    req_valid_nxt = req_valid;
    req_idx_nxt   = req_idx;
    clr           = '0;
    unique case (state)
      IDLE: begin
        if (en && enc_valid) begin
          req_idx_nxt   = enc_out;
          req_valid_nxt = 1'b1;
          state_nxt     = GRANT;
        end
      end
      GRANT: begin
        // The grant holds against preemption, en falling and masking until ack.
        if (ack) begin
          clr[req_idx]  = 1'b1;
          req_valid_nxt = 1'b0;
          state_nxt     = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    pending_nxt = (pending & ~clr) | rise;
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      irq_prev  <= '0;
      pending   <= '0;
      req_valid <= 1'b0;
      req_idx   <= '0;
    end else begin
      state     <= state_nxt;
      irq_prev  <= irq_in;
      pending   <= pending_nxt;
      req_valid <= req_valid_nxt;
      req_idx   <= req_idx_nxt;
    end
  end

endmodule

// File: tb/tb_irq_pending_ctrl.sv
// Self-checking bench for irq_pending_ctrl. It runs directed scenarios and then
// randomized traffic. All checks compare against a behavioural reference model.
module tb_irq_pending_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] irq_in;
  logic [7:0] mask;
  logic [7:0] pending;
  logic       req_valid;
  logic [2:0] req_idx;
  logic       ack;

  int checks = 0;
  int errors = 0;

  // Reference model. gnt is the outstanding grant index, or -1 when nothing is granted.
  bit [7:0] m_pend;
  bit [7:0] m_prev;
  int       gnt;
  int       m_idx;

  irq_pending_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .irq_in    (irq_in),
    .mask      (mask),
    .pending   (pending),
    .req_valid (req_valid),
    .req_idx   (req_idx),
    .ack       (ack)
  );

  always #5 clk = ~clk;

  // Advances one clock, updates the model from the inputs sampled at that edge,
  // and returns at the falling edge, ready for checks and new stimulus.
  task automatic tick();
    int       win;
    bit [7:0] np;
    @(posedge clk);
    if (rst) begin
      m_pend = '0;
      m_prev = '0;
      gnt    = -1;
      m_idx  = 0;
    end else begin
      win = -1;
      for (int i = 7; i >= 0; i--)
        if (m_pend[i] && !mask[i]) begin
          win = i;
          break;
        end
      for (int i = 0; i < 8; i++)
        np[i] = (m_pend[i] && !(gnt == i && ack)) || (irq_in[i] && !m_prev[i]);
      if (gnt >= 0) begin
        if (ack) gnt = -1;
      end else if (en && win >= 0) begin
        gnt   = win;
        m_idx = win;
      end
      m_pend = np;
      m_prev = irq_in;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; irq_in = '0; mask = '0; ack = 1'b0;
    tick(); tick();
    checks++;
    if (pending !== 8'h00 || req_valid !== 1'b0 || req_idx !== 3'd0) begin
      errors++;
      $display("FAIL reset: pending=%h valid=%b idx=%0d, want 00 0 0", pending, req_valid, req_idx);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    en = 1'b1; mask = '0;
    irq_in = 8'h04; tick();
    checks++;
    if (pending !== 8'h04 || req_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_pend: pending=%h valid=%b, want 04 0", pending, req_valid);
    end
    irq_in = 8'h00; tick();
    checks++;
    if (req_valid !== 1'b1 || req_idx !== 3'd2) begin
      errors++;
      $display("FAIL single_grant: valid=%b idx=%0d, want 1 2", req_valid, req_idx);
    end
    ack = 1'b1; tick(); ack = 1'b0;
    checks++;
    if (pending !== 8'h00 || req_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_ack: pending=%h valid=%b, want 00 0", pending, req_valid);
    end
  endtask

  task automatic test_priority();
    int exp_q[$] = '{5, 3, 2, 1};
    irq_in = 8'h2E; tick();
    irq_in = 8'h00; tick();
    foreach (exp_q[k]) begin
      checks++;
      if (req_valid !== 1'b1 || req_idx !== 3'(exp_q[k])) begin
        errors++;
        $display("FAIL priority_%0d: valid=%b idx=%0d, want 1 %0d", k, req_valid, req_idx, exp_q[k]);
      end
      ack = 1'b1; tick(); ack = 1'b0;
      checks++;
      if (req_valid !== 1'b0) begin
        errors++;
        $display("FAIL priority_idle_%0d: valid=%b, want 0", k, req_valid);
      end
      tick();
    end
    checks++;
    if (pending !== 8'h00 || req_valid !== 1'b0) begin
      errors++;
      $display("FAIL priority_drain: pending=%h valid=%b, want 00 0", pending, req_valid);
    end
  endtask

  task automatic test_no_preempt();
    irq_in = 8'h02; tick();
    irq_in = 8'h00; tick();
    irq_in = 8'h80; tick();
    irq_in = 8'h00; tick();
    checks++;
    if (req_valid !== 1'b1 || req_idx !== 3'd1 || pending !== 8'h82) begin
      errors++;
      $display("FAIL no_preempt: valid=%b idx=%0d pending=%h, want 1 1 82", req_valid, req_idx, pending);
    end
    ack = 1'b1; tick(); ack = 1'b0;
    tick();
    checks++;
    if (req_valid !== 1'b1 || req_idx !== 3'd7) begin
      errors++;
      $display("FAIL no_preempt_next: valid=%b idx=%0d, want 1 7", req_valid, req_idx);
    end
    ack = 1'b1; tick(); ack = 1'b0;
  endtask

  task automatic test_mask();
    mask = 8'h80;
    irq_in = 8'h81; tick();
    irq_in = 8'h00; tick();
    checks++;
    if (req_valid !== 1'b1 || req_idx !== 3'd0 || pending !== 8'h81) begin
      errors++;
      $display("FAIL mask_grant: valid=%b idx=%0d pending=%h, want 1 0 81", req_valid, req_idx, pending);
    end
    ack = 1'b1; tick(); ack = 1'b0;
    tick();
    checks++;
    if (req_valid !== 1'b0 || pending !== 8'h80) begin
      errors++;
      $display("FAIL mask_hold: valid=%b pending=%h, want 0 80", req_valid, pending);
    end
    mask = 8'h00; tick();
    checks++;
    if (req_valid !== 1'b1 || req_idx !== 3'd7) begin
      errors++;
      $display("FAIL mask_clear: valid=%b idx=%0d, want 1 7", req_valid, req_idx);
    end
    ack = 1'b1; tick(); ack = 1'b0;
  endtask

  task automatic test_set_wins();
    irq_in = 8'h08; tick();
    irq_in = 8'h00; tick();
    checks++;
    if (req_valid !== 1'b1 || req_idx !== 3'd3) begin
      errors++;
      $display("FAIL setwin_grant: valid=%b idx=%0d, want 1 3", req_valid, req_idx);
    end
    irq_in = 8'h08; ack = 1'b1; tick();
    irq_in = 8'h00; ack = 1'b0;
    checks++;
    if (pending !== 8'h08 || req_valid !== 1'b0) begin
      errors++;
      $display("FAIL setwin_pend: pending=%h valid=%b, want 08 0", pending, req_valid);
    end
    tick();
    checks++;
    if (req_valid !== 1'b1 || req_idx !== 3'd3) begin
      errors++;
      $display("FAIL setwin_regrant: valid=%b idx=%0d, want 1 3", req_valid, req_idx);
    end
    ack = 1'b1; tick(); ack = 1'b0;
  endtask

  task automatic test_held_high();
    irq_in = 8'h40; tick();
    tick();
    ack = 1'b1; tick(); ack = 1'b0;
    tick(); tick();
    checks++;
    if (pending !== 8'h00 || req_valid !== 1'b0) begin
      errors++;
      $display("FAIL held_high: pending=%h valid=%b, want 00 0", pending, req_valid);
    end
    irq_in = 8'h00; tick();
  endtask

  task automatic test_en_reset();
    en = 1'b0;
    irq_in = 8'h10; tick();
    irq_in = 8'h00; tick(); tick();
    checks++;
    if (pending !== 8'h10 || req_valid !== 1'b0) begin
      errors++;
      $display("FAIL en_off: pending=%h valid=%b, want 10 0", pending, req_valid);
    end
    en = 1'b1; tick();
    checks++;
    if (req_valid !== 1'b1 || req_idx !== 3'd4) begin
      errors++;
      $display("FAIL en_on: valid=%b idx=%0d, want 1 4", req_valid, req_idx);
    end
    rst = 1'b1; tick(); rst = 1'b0;
    checks++;
    if (req_valid !== 1'b0 || pending !== 8'h00) begin
      errors++;
      $display("FAIL rst_grant: valid=%b pending=%h, want 0 00", req_valid, pending);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      irq_in = 8'($urandom) & 8'($urandom);
      mask   = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      en     = ($urandom_range(0, 7) != 0);
      ack    = ($urandom_range(0, 2) == 0);
      rst    = ($urandom_range(0, 299) == 0);
      tick();
      checks++;
      if (pending !== m_pend || req_valid !== (gnt >= 0) || req_idx !== 3'(m_idx)) begin
        errors++;
        $display("FAIL random_%0d: pending=%h valid=%b idx=%0d, want %h %b %0d",
                 c, pending, req_valid, req_idx, m_pend, gnt >= 0, m_idx);
      end
    end
    rst = 1'b0; ack = 1'b0; irq_in = '0; mask = '0;
  endtask

  initial begin
    m_pend = '0; m_prev = '0; gnt = -1; m_idx = 0;
    test_reset();
    test_single();
    test_priority();
    test_no_preempt();
    test_mask();
    test_set_wins();
    test_held_high();
    test_en_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
